// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg
//   Shared definitions for the SPI NOR flash byte engine: engine state
//   encoding, the flash opcodes the controller frames, default timing
//   constants and a small width helper.
package spi_flash_pkg;

  // Engine states. Prefixed so they never collide with timing parameter names.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_WAIT     = 3'd3,
    ST_CS_HOLD  = 3'd4,
    ST_CS_IDLE  = 3'd5
  } spi_state_e;

  // Flash opcodes issued by the controller as the first byte of a frame.
  localparam logic [7:0] OP_RD   = 8'h03;
  localparam logic [7:0] OP_PP   = 8'h02;
  localparam logic [7:0] OP_RDID = 8'h9F;
  localparam logic [7:0] OP_RDSR = 8'h05;
  localparam logic [7:0] OP_WREN = 8'h06;

  // Default timing, all in p_clk cycles.
  localparam int DEF_CLK_DIV  = 4;
  localparam int DEF_CS_SETUP = 2;
  localparam int DEF_CS_HOLD  = 2;
  localparam int DEF_CS_IDLE  = 4;

  // Largest of three values; sizes the shared framing timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return m;
  endfunction

endpackage

// File: rtl/spi_byte_engine_if.sv
// spi_byte_engine_if
//   Byte-level handshake between the flash controller (master) and the
//   SPI byte engine (slave).
//   tx_data/tx_last/tx_valid : byte offered by the controller
//   tx_ready                 : engine accepts the byte this cycle
//   rx_data/rx_valid         : received byte, rx_valid pulses one cycle
//   busy                     : frame in progress
interface spi_byte_engine_if;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       busy;

  modport master (
    output tx_data, tx_last, tx_valid,
    input  tx_ready, rx_data, rx_valid, busy
  );

  modport slave (
    input  tx_data, tx_last, tx_valid,
    output tx_ready, rx_data, rx_valid, busy
  );
endinterface

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen
//   SPI clock divider for the byte engine. While en is high, div_cnt runs
//   0..CLK_DIV-1 and the phase flips on every terminal count, so one s_clk
//   period is 2*CLK_DIV p_clk cycles. When en is low the divider is held at
//   the start of a low phase, so re-enabling always begins a fresh bit.
//   clk/rst    : system clock, synchronous active-high reset
//   en         : divider runs (engine is shifting)
//   rise_tick  : this cycle ends the low phase (s_clk rises at the edge)
//   fall_tick  : this cycle ends the high phase (s_clk falls at the edge)
//   s_clk      : registered SPI clock, idles low
module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic rise_tick,
  output logic fall_tick,
  output logic s_clk
);

  localparam int DIV_W = $clog2(CLK_DIV) + 1;

  logic [DIV_W-1:0] div_cnt_r;
  logic             phase_r;
  logic             term_s;

  assign term_s    = (div_cnt_r == DIV_W'(CLK_DIV - 1));
  assign rise_tick = en & term_s & ~phase_r;
  assign fall_tick = en & term_s & phase_r;
  // The phase register is the SPI clock itself: high phase means s_clk=1.
  assign s_clk     = phase_r;

  // Divider counter and phase flip-flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_r <= {DIV_W{1'b0}};
      phase_r   <= 1'b0;
    end else if (!en) begin
      div_cnt_r <= {DIV_W{1'b0}};
      phase_r   <= 1'b0;
    end else if (term_s) begin
      div_cnt_r <= {DIV_W{1'b0}};
      phase_r   <= ~phase_r;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_W'(1);
      phase_r   <= phase_r;
    end
  end

endmodule

// File: rtl/spi_byte_engine.sv
// spi_byte_engine
//   Serial stage of the APB-to-SPI NOR flash controller. Takes a framed
//   stream of bytes, shifts each MSB-first on a mode-0 SPI bus and returns
//   each byte captured from s_miso. Owns chip-select framing and the
//   setup/hold/idle timing around each frame.
//   p_clk/p_reset : system clock, synchronous active-high reset
//   bus           : byte handshake (slave side)
//   s_clk         : SPI clock, idles low
//   s_css         : chip select, active low
//   s_mosi/s_miso : serial data to/from the flash
module spi_byte_engine
  import spi_flash_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int CS_SETUP = DEF_CS_SETUP,
  parameter int CS_HOLD  = DEF_CS_HOLD,
  parameter int CS_IDLE  = DEF_CS_IDLE
) (
  input  logic              p_clk,
  input  logic              p_reset,
  spi_byte_engine_if.slave  bus,
  output logic              s_clk,
  output logic              s_css,
  output logic              s_mosi,
  input  logic              s_miso
);

  // One timer serves setup, hold and idle since they never overlap.
  localparam int TMR_MAX = max3(CS_SETUP, CS_HOLD, CS_IDLE);
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;

  spi_state_e       state_r, state_nx;
  logic [TMR_W-1:0] tmr_r, tmr_nx;
  logic [2:0]       bit_cnt_r, bit_cnt_nx;
  logic [7:0]       tx_shift_r, tx_shift_nx;
  logic             last_r, last_nx;
  logic [7:0]       rx_shift_r, rx_shift_nx;
  logic [7:0]       rx_data_r, rx_data_nx;
  logic             rx_valid_r, rx_valid_nx;
  logic             s_css_r, css_nx;
  logic             s_mosi_r, mosi_nx;
  logic             ready_s;
  logic             sclk_en_s;
  logic             rise_tick_s;
  logic             fall_tick_s;

  assign sclk_en_s = (state_r == ST_SHIFT);

  spi_sclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sclk_gen (
    .clk       (p_clk),
    .rst       (p_reset),
    .en        (sclk_en_s),
    .rise_tick (rise_tick_s),
    .fall_tick (fall_tick_s),
    .s_clk     (s_clk)
  );

  assign s_css        = s_css_r;
  assign s_mosi       = s_mosi_r;
  assign bus.rx_data  = rx_data_r;
  assign bus.rx_valid = rx_valid_r;
  assign bus.busy     = (state_r != ST_IDLE);
  // Ready never depends on tx_valid, and is forced low while in reset.
  assign bus.tx_ready = ready_s & ~p_reset;

  // Next-state, datapath and handshake decode for the framing FSM.
  always_comb begin
    state_nx    = state_r;
    tmr_nx      = tmr_r;
    bit_cnt_nx  = bit_cnt_r;
    tx_shift_nx = tx_shift_r;
    last_nx     = last_r;
    rx_shift_nx = rx_shift_r;
    rx_data_nx  = rx_data_r;
    rx_valid_nx = 1'b0;
    css_nx      = s_css_r;
    mosi_nx     = s_mosi_r;
    ready_s     = 1'b0;

    case (state_r)
      ST_IDLE: begin
        ready_s = 1'b1;
        if (bus.tx_valid) begin
          tx_shift_nx = bus.tx_data;
          last_nx     = bus.tx_last;
          bit_cnt_nx  = 3'd7;
          mosi_nx     = bus.tx_data[7];
          css_nx      = 1'b0;
          tmr_nx      = {TMR_W{1'b0}};
          state_nx    = ST_CS_SETUP;
        end else begin
          state_nx = ST_IDLE;
        end
      end

      ST_CS_SETUP: begin
        if (tmr_r == TMR_W'(CS_SETUP - 1)) begin
          tmr_nx   = {TMR_W{1'b0}};
          state_nx = ST_SHIFT;
        end else begin
          tmr_nx = tmr_r + TMR_W'(1);
        end
      end

      ST_SHIFT: begin
        // Sample on the edge that raises s_clk.
        if (rise_tick_s) begin
          rx_shift_nx = {rx_shift_r[6:0], s_miso};
        end else begin
          rx_shift_nx = rx_shift_r;
        end

        if (fall_tick_s) begin
          if (bit_cnt_r != 3'd0) begin
            // s_mosi only moves together with the falling s_clk.
            bit_cnt_nx  = bit_cnt_r - 3'd1;
            tx_shift_nx = {tx_shift_r[6:0], 1'b0};
            mosi_nx     = tx_shift_r[6];
          end else begin
            rx_data_nx  = rx_shift_r;
            rx_valid_nx = 1'b1;
            if (last_r) begin
              tmr_nx   = {TMR_W{1'b0}};
              state_nx = ST_CS_HOLD;
            end else begin
              // Byte-done of a non-last byte: a byte taken here keeps the
              // divider running, so the s_clk period is unbroken.
              ready_s = 1'b1;
              if (bus.tx_valid) begin
                tx_shift_nx = bus.tx_data;
                last_nx     = bus.tx_last;
                bit_cnt_nx  = 3'd7;
                mosi_nx     = bus.tx_data[7];
                state_nx    = ST_SHIFT;
              end else begin
                state_nx = ST_WAIT;
              end
            end
          end
        end else begin
          state_nx = ST_SHIFT;
        end
      end

      ST_WAIT: begin
        // Chip select stays low; the divider is parked at a low phase.
        ready_s = 1'b1;
        if (bus.tx_valid) begin
          tx_shift_nx = bus.tx_data;
          last_nx     = bus.tx_last;
          bit_cnt_nx  = 3'd7;
          mosi_nx     = bus.tx_data[7];
          state_nx    = ST_SHIFT;
        end else begin
          state_nx = ST_WAIT;
        end
      end

      ST_CS_HOLD: begin
        if (tmr_r == TMR_W'(CS_HOLD - 1)) begin
          css_nx   = 1'b1;
          tmr_nx   = {TMR_W{1'b0}};
          state_nx = ST_CS_IDLE;
        end else begin
          tmr_nx = tmr_r + TMR_W'(1);
        end
      end

      ST_CS_IDLE: begin
        if (tmr_r == TMR_W'(CS_IDLE - 1)) begin
          tmr_nx   = {TMR_W{1'b0}};
          state_nx = ST_IDLE;
        end else begin
          tmr_nx = tmr_r + TMR_W'(1);
        end
      end

      default: begin
        css_nx   = 1'b1;
        tmr_nx   = {TMR_W{1'b0}};
        state_nx = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame in progress.
  always_ff @(posedge p_clk) begin
    if (p_reset) begin
      state_r    <= ST_IDLE;
      tmr_r      <= {TMR_W{1'b0}};
      bit_cnt_r  <= 3'd0;
      tx_shift_r <= 8'h00;
      last_r     <= 1'b0;
      rx_shift_r <= 8'h00;
      rx_data_r  <= 8'h00;
      rx_valid_r <= 1'b0;
      s_css_r    <= 1'b1;
      s_mosi_r   <= 1'b0;
    end else begin
      state_r    <= state_nx;
      tmr_r      <= tmr_nx;
      bit_cnt_r  <= bit_cnt_nx;
      tx_shift_r <= tx_shift_nx;
      last_r     <= last_nx;
      rx_shift_r <= rx_shift_nx;
      rx_data_r  <= rx_data_nx;
      rx_valid_r <= rx_valid_nx;
      s_css_r    <= css_nx;
      s_mosi_r   <= mosi_nx;
    end
  end

endmodule

// File: tb/tb_spi_byte_engine.sv
// tb_spi_byte_engine
//   Directed bench for spi_byte_engine at default timing. A table of
//   single-byte frames is replayed, followed by hand-written multi-byte,
//   stall, abort and idle-gap sequences. A flash model either loops s_mosi
//   back or shifts out a fixed response byte MSB-first.
module tb_spi_byte_engine;
  import spi_flash_pkg::*;

  logic p_clk = 1'b0;
  logic p_reset;
  logic s_clk, s_css, s_mosi, s_miso;

  spi_byte_engine_if bus();

  spi_byte_engine dut (
    .p_clk   (p_clk),
    .p_reset (p_reset),
    .bus     (bus),
    .s_clk   (s_clk),
    .s_css   (s_css),
    .s_mosi  (s_mosi),
    .s_miso  (s_miso)
  );

  always #5 p_clk = ~p_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Flash model
  logic       miso_loop = 1'b1;
  logic [7:0] miso_resp = 8'h00;
  logic [2:0] mrise     = 3'd0;
  assign s_miso = miso_loop ? s_mosi : miso_resp[3'd7 - mrise];

  // Monitor: values read at posedge are those of the cycle just ending.
  int         cyc = 0;
  int         n_rise = 0, n_rx = 0, n_css_fall = 0, n_css_rise = 0;
  int         n_busy_fall = 0, mosi_err = 0;
  int         rise_cyc [512];
  logic       rise_mosi [512];
  logic [7:0] rx_log [64];
  int         css_fall_cyc [64];
  int         css_rise_cyc [64];
  int         busy_fall_cyc [64];
  logic       s_clk_q = 1'b0, s_mosi_q = 1'b0, s_css_q = 1'b1, busy_q = 1'b0;

  always @(posedge p_clk) begin
    cyc <= cyc + 1;
    if (s_clk === 1'b1 && s_clk_q === 1'b0) begin
      rise_cyc[n_rise[8:0]]  <= cyc;
      rise_mosi[n_rise[8:0]] <= s_mosi;
      n_rise <= n_rise + 1;
      mrise  <= mrise + 3'd1;
    end else if (s_css === 1'b1) begin
      mrise <= 3'd0;
    end
    if (bus.rx_valid === 1'b1) begin
      rx_log[n_rx[5:0]] <= bus.rx_data;
      n_rx <= n_rx + 1;
    end
    if (s_css === 1'b0 && s_css_q === 1'b1) begin
      css_fall_cyc[n_css_fall[5:0]] <= cyc;
      n_css_fall <= n_css_fall + 1;
    end
    if (s_css === 1'b1 && s_css_q === 1'b0) begin
      css_rise_cyc[n_css_rise[5:0]] <= cyc;
      n_css_rise <= n_css_rise + 1;
    end
    if (bus.busy === 1'b0 && busy_q === 1'b1) begin
      busy_fall_cyc[n_busy_fall[5:0]] <= cyc;
      n_busy_fall <= n_busy_fall + 1;
    end
    if (s_mosi !== s_mosi_q && s_clk === 1'b1) mosi_err <= mosi_err + 1;
    s_clk_q  <= s_clk;
    s_mosi_q <= s_mosi;
    s_css_q  <= s_css;
    busy_q   <= bus.busy;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mosi_word(input int start, input int n);
    logic [31:0] w;
    int idx;
    w = 32'd0;
    for (int k = 0; k < n; k++) begin
      idx = start + k;
      w = {w[30:0], rise_mosi[idx[8:0]]};
    end
    return w;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send_byte(input logic [7:0] d, input logic l, input string name);
    int n;
    bus.tx_data  = d;
    bus.tx_last  = l;
    bus.tx_valid = 1'b1;
    n = 0;
    while (bus.tx_ready !== 1'b1 && n < 3000) begin
      @(negedge p_clk);
      n++;
    end
    check({name, "_accept"}, 32'(bus.tx_ready), 32'd1);
    @(negedge p_clk);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 3000) begin
      @(negedge p_clk);
      n++;
    end
    check({name, "_idle"}, 32'(bus.busy), 32'd0);
    @(negedge p_clk);
    @(negedge p_clk);
  endtask

  typedef struct packed {
    logic [7:0] tx;
    logic       loop;
    logic [7:0] resp;
    logic [7:0] exp_rx;
    logic [7:0] exp_mosi;
  } vec_t;

  vec_t vecs [5];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, x0, c0, b0, n, bad, lo;

    vecs[0] = '{tx: 8'hA5,    loop: 1'b1, resp: 8'h00, exp_rx: 8'hA5, exp_mosi: 8'hA5};
    vecs[1] = '{tx: OP_RD,    loop: 1'b1, resp: 8'h00, exp_rx: 8'h03, exp_mosi: 8'h03};
    vecs[2] = '{tx: 8'hFF,    loop: 1'b1, resp: 8'h00, exp_rx: 8'hFF, exp_mosi: 8'hFF};
    vecs[3] = '{tx: OP_WREN,  loop: 1'b0, resp: 8'h5A, exp_rx: 8'h5A, exp_mosi: 8'h06};
    vecs[4] = '{tx: OP_RDID,  loop: 1'b0, resp: 8'hC2, exp_rx: 8'hC2, exp_mosi: 8'h9F};

    p_reset      = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    bus.tx_last  = 1'b0;
    repeat (3) @(negedge p_clk);
    p_reset = 1'b0;
    repeat (2) @(negedge p_clk);

    // Reset in idle with a byte offered: nothing is accepted.
    p_reset      = 1'b1;
    bus.tx_valid = 1'b1;
    bus.tx_data  = OP_PP;
    repeat (3) @(negedge p_clk);
    check("rst_css",      32'(s_css), 32'd1);
    check("rst_sclk",     32'(s_clk), 32'd0);
    check("rst_mosi",     32'(s_mosi), 32'd0);
    check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    check("rst_rx_data",  32'(bus.rx_data), 32'd0);
    check("rst_busy",     32'(bus.busy), 32'd0);
    check("rst_tx_ready", 32'(bus.tx_ready), 32'd0);
    bus.tx_valid = 1'b0;
    p_reset      = 1'b0;
    @(negedge p_clk);
    check("idle_tx_ready", 32'(bus.tx_ready), 32'd1);

    // Single-byte frames from the table.
    for (int i = 0; i < 5; i++) begin
      miso_loop = vecs[i].loop;
      miso_resp = vecs[i].resp;
      r0 = n_rise; x0 = n_rx; c0 = n_css_fall; b0 = n_busy_fall;
      send_byte(vecs[i].tx, 1'b1, $sformatf("vec%0d", i));
      bus.tx_valid = 1'b0;
      wait_idle($sformatf("vec%0d", i));
      check($sformatf("vec%0d_rx_count", i), n_rx - x0, 32'd1);
      check($sformatf("vec%0d_rx_data", i), 32'(rx_log[x0[5:0]]), 32'(vecs[i].exp_rx));
      check($sformatf("vec%0d_rises", i), n_rise - r0, 32'd8);
      check($sformatf("vec%0d_mosi", i), mosi_word(r0, 8), 32'(vecs[i].exp_mosi));
      check($sformatf("vec%0d_css_low", i), css_rise_cyc[c0[5:0]] - css_fall_cyc[c0[5:0]], 32'd68);
      check($sformatf("vec%0d_busy_tail", i), busy_fall_cyc[b0[5:0]] - css_rise_cyc[c0[5:0]], 32'd4);
    end

    // Back-to-back frame with tx_valid held.
    miso_loop = 1'b1;
    r0 = n_rise; x0 = n_rx; c0 = n_css_fall;
    send_byte(OP_RD, 1'b0, "b2b0");
    send_byte(8'h12, 1'b0, "b2b1");
    send_byte(8'h34, 1'b0, "b2b2");
    send_byte(8'h56, 1'b1, "b2b3");
    bus.tx_valid = 1'b0;
    wait_idle("b2b");
    check("b2b_rises", n_rise - r0, 32'd32);
    bad = 0;
    for (int k = 1; k < 32; k++) begin
      n = r0 + k;
      b0 = n - 1;
      if (rise_cyc[n[8:0]] - rise_cyc[b0[8:0]] != 8) bad++;
    end
    check("b2b_period_errs", bad, 32'd0);
    check("b2b_mosi", mosi_word(r0, 32), 32'h03123456);
    check("b2b_rx_count", n_rx - x0, 32'd4);
    check("b2b_rx0", 32'(rx_log[x0[5:0]]), 32'h03);
    n = x0 + 3;
    check("b2b_rx3", 32'(rx_log[n[5:0]]), 32'h56);
    check("b2b_css_frames", n_css_fall - c0, 32'd1);
    check("b2b_css_low", css_rise_cyc[c0[5:0]] - css_fall_cyc[c0[5:0]], 32'd260);

    // Stall between bytes; flash answers 0xEF.
    miso_loop = 1'b0;
    miso_resp = 8'hEF;
    r0 = n_rise; x0 = n_rx; c0 = n_css_fall;
    send_byte(OP_RDID, 1'b0, "stall0");
    bus.tx_valid = 1'b0;
    n = 0;
    while (n_rx == x0 && n < 500) begin
      @(negedge p_clk);
      n++;
    end
    check("stall_first_rx", n_rx - x0, 32'd1);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      if (s_clk !== 1'b0 || s_css !== 1'b0 || bus.tx_ready !== 1'b1 || bus.busy !== 1'b1) bad++;
      @(negedge p_clk);
    end
    check("stall_gap_errs", bad, 32'd0);
    send_byte(8'h00, 1'b1, "stall1");
    bus.tx_valid = 1'b0;
    wait_idle("stall");
    check("stall_rx_count", n_rx - x0, 32'd2);
    n = x0 + 1;
    check("stall_rx1", 32'(rx_log[n[5:0]]), 32'hEF);
    check("stall_rises", n_rise - r0, 32'd16);
    check("stall_css_frames", n_css_fall - c0, 32'd1);

    // Abort after the third s_clk rise.
    miso_loop = 1'b1;
    r0 = n_rise; x0 = n_rx;
    send_byte(8'h81, 1'b1, "abort");
    bus.tx_valid = 1'b0;
    n = 0;
    while (n_rise - r0 < 3 && n < 500) begin
      @(negedge p_clk);
      n++;
    end
    check("abort_third_rise", n_rise - r0, 32'd3);
    p_reset = 1'b1;
    @(negedge p_clk);
    check("abort_css", 32'(s_css), 32'd1);
    check("abort_sclk", 32'(s_clk), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd0);
    repeat (2) @(negedge p_clk);
    p_reset = 1'b0;
    repeat (100) @(negedge p_clk);
    check("abort_no_rx", n_rx - x0, 32'd0);
    r0 = n_rise; x0 = n_rx; c0 = n_css_fall;
    send_byte(OP_RDSR, 1'b1, "after_abort");
    bus.tx_valid = 1'b0;
    wait_idle("after_abort");
    check("after_abort_rx", 32'(rx_log[x0[5:0]]), 32'h05);
    check("after_abort_mosi", mosi_word(r0, 8), 32'h05);
    check("after_abort_css_low", css_rise_cyc[c0[5:0]] - css_fall_cyc[c0[5:0]], 32'd68);

    // Byte offered while chip select is in its idle gap.
    x0 = n_rx; c0 = n_css_fall;
    send_byte(OP_WREN, 1'b1, "gap0");
    bus.tx_valid = 1'b0;
    n = 0;
    while (s_css !== 1'b1 && n < 500) begin
      @(negedge p_clk);
      n++;
    end
    lo = 0;
    while (bus.tx_ready !== 1'b1 && lo < 50) begin
      lo++;
      if (lo == 1) begin
        bus.tx_data  = 8'h3C;
        bus.tx_last  = 1'b1;
        bus.tx_valid = 1'b1;
      end
      @(negedge p_clk);
    end
    check("gap_ready_low", lo, 32'd4);
    check("gap_accept_idle", 32'(bus.busy), 32'd0);
    @(negedge p_clk);
    bus.tx_valid = 1'b0;
    wait_idle("gap1");
    n = x0 + 1;
    check("gap_rx1", 32'(rx_log[n[5:0]]), 32'h3C);
    n = c0 + 1;
    check("gap_css_high", css_fall_cyc[n[5:0]] - css_rise_cyc[c0[5:0]], 32'd5);

    check("mosi_only_while_sclk_low", mosi_err, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
